// File: rtl/tex_mem_latency_model.sv
// ============================================================================
// tex_mem_latency_model : synthetic texture memory with in-order, fixed-latency
// responses.  Optional random stalls: define TEX_MEM_SIM_STALL_EN.  Rev 1.0
// ============================================================================
`default_nettype none

`ifndef TEX_FILTER_BITS
`define TEX_FILTER_BITS 1
`endif
`ifndef TEX_LGSTRIDE_BITS
`define TEX_LGSTRIDE_BITS 2
`endif

module tex_mem_latency_model #(
  parameter int          NUM_REQS    = 4,
  parameter int          REQ_INFOW   = 8,
  parameter int          LATENCY     = 4,
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] DATA_SEED   = 32'hC0DE_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [NUM_REQS-1:0]           req_tmask,
  input  logic [`TEX_FILTER_BITS-1:0]   req_filter,
  input  logic [`TEX_LGSTRIDE_BITS-1:0] req_lgstride,
  input  logic [NUM_REQS*32-1:0]        req_baseaddr,
  input  logic [NUM_REQS*4*32-1:0]      req_addr,
  input  logic [REQ_INFOW-1:0]          req_info,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [NUM_REQS-1:0]           rsp_tmask,
  output logic [NUM_REQS*4*32-1:0]      rsp_data,
  output logic [REQ_INFOW-1:0]          rsp_info,
  input  logic                          rsp_ready
);

  localparam int DW = NUM_REQS * 4 * 32;
  localparam int EW = NUM_REQS + DW + REQ_INFOW;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] QD_C = CW'(QUEUE_DEPTH);

  logic                               rdy_en_q, rdy_en_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [CW-1:0]                      fcnt_q, fcnt_d;
  logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                      rd_ptr_q, rd_ptr_d;
  logic [LATENCY-1:0]                 stg_vld_q, stg_vld_d;
  logic [LATENCY-1:0][NUM_REQS-1:0]   stg_tmask_q, stg_tmask_d;
  logic [LATENCY-1:0][DW-1:0]         stg_data_q, stg_data_d;
  logic [LATENCY-1:0][REQ_INFOW-1:0]  stg_info_q, stg_info_d;
  logic [EW-1:0]                      mem_q [QUEUE_DEPTH];

  logic [DW-1:0] acc_data;
  logic [1:0]    shift;
  logic          accept;
  logic          push;
  logic          pop;
  logic          head_avail;
  logic          stall_ok;

  function automatic logic [31:0] texel(input logic [31:0] base,
                                        input logic [31:0] idx,
                                        input logic [1:0]  sh);
    logic [31:0] a;
    logic [31:0] m;
    a = base + (idx << sh);
    m = {a[17:2], ~a[17:2]} ^ DATA_SEED;
    case (sh)
      2'd0: begin
        case (a[1:0])
          2'd0:    texel = {24'h0, m[7:0]};
          2'd1:    texel = {24'h0, m[15:8]};
          2'd2:    texel = {24'h0, m[23:16]};
          default: texel = {24'h0, m[31:24]};
        endcase
      end
      2'd1:    texel = a[1] ? {16'h0, m[31:16]} : {16'h0, m[15:0]};
      default: texel = m;
    endcase
  endfunction

  // Strides of 32 bits and wider all read whole words.
  assign shift = (req_lgstride > `TEX_LGSTRIDE_BITS'(1)) ? 2'd2 : 2'(req_lgstride);

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (req_tmask[i] && (j == 0 || req_filter != '0)) begin
          acc_data[(i*4+j)*32 +: 32] = texel(req_baseaddr[i*32 +: 32],
                                             req_addr[(i*4+j)*32 +: 32], shift);
        end
      end
    end
  end

  // A pop frees a credit in the same cycle, so a full queue can still accept.
  assign req_ready = rdy_en_q && stall_ok && ((cnt_q < QD_C) || pop);
  assign accept    = req_valid && req_ready;
  assign push      = stg_vld_q[LATENCY-1];
  assign pop       = head_avail && rsp_ready;
  assign rsp_valid = head_avail;
  assign {rsp_tmask, rsp_data, rsp_info} = head_avail ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    stg_vld_d[0]   = accept;
    stg_tmask_d[0] = req_tmask;
    stg_data_d[0]  = acc_data;
    stg_info_d[0]  = req_info;
    for (int k = 1; k < LATENCY; k++) begin
      stg_vld_d[k]   = stg_vld_q[k-1];
      stg_tmask_d[k] = stg_tmask_q[k-1];
      stg_data_d[k]  = stg_data_q[k-1];
      stg_info_d[k]  = stg_info_q[k-1];
    end
  end

  always_comb begin
    rdy_en_d = 1'b1;
    cnt_d    = cnt_q + CW'(accept) - CW'(pop);
    fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q  <= 1'b0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      stg_vld_q <= '0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      stg_vld_q <= stg_vld_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    stg_tmask_q <= stg_tmask_d;
    stg_data_q  <= stg_data_d;
    stg_info_q  <= stg_info_d;
    if (push) begin
      mem_q[wr_ptr_q] <= {stg_tmask_q[LATENCY-1], stg_data_q[LATENCY-1],
                          stg_info_q[LATENCY-1]};
    end
  end

`ifdef TEX_MEM_SIM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  hold_q, hold_d;
  logic [1:0]  dly_q [QUEUE_DEPTH];

  // hold_q counts down the extra wait of whichever entry currently sits at the head.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    hold_d = hold_q;
    if (pop) begin
      if (fcnt_q > CW'(1)) begin
        hold_d = dly_q[PW'(rd_ptr_q + 1'b1)];
      end else if (push) begin
        hold_d = lfsr_q[3:2];
      end else begin
        hold_d = 2'd0;
      end
    end else if (fcnt_q == '0) begin
      hold_d = push ? lfsr_q[3:2] : 2'd0;
    end else if (hold_q != 2'd0) begin
      hold_d = hold_q - 2'd1;
    end
  end

  assign stall_ok   = (lfsr_q[1:0] != 2'b00);
  assign head_avail = (fcnt_q != '0) && (hold_q == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
      hold_q <= 2'd0;
    end else begin
      lfsr_q <= lfsr_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dly_q[wr_ptr_q] <= lfsr_q[3:2];
    end
  end
`else
  assign stall_ok   = 1'b1;
  assign head_avail = (fcnt_q != '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (LATENCY >= 1) else $error("LATENCY must be at least 1");
      assert (QUEUE_DEPTH >= LATENCY) else $error("QUEUE_DEPTH must cover LATENCY");
      assert (!(push && fcnt_q == QD_C)) else $error("response fifo overflow");
      assert (!(pop && fcnt_q == '0)) else $error("response fifo underflow");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tex_mem_latency_model.sv
// ============================================================================
// tb_tex_mem_latency_model : directed + random bench with a queue-based model
// of the texture memory.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_tex_mem_latency_model;

  localparam int          NR   = 4;
  localparam int          IW   = 8;
  localparam int          LAT  = 4;
  localparam int          QD   = 8;
  localparam logic [31:0] SEED = 32'hC0DE_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [NR-1:0]     req_tmask = '0;
  logic [0:0]        req_filter = '0;
  logic [1:0]        req_lgstride = '0;
  logic [NR*32-1:0]  req_baseaddr = '0;
  logic [NR*128-1:0] req_addr = '0;
  logic [IW-1:0]     req_info = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [NR-1:0]     rsp_tmask;
  logic [NR*128-1:0] rsp_data;
  logic [IW-1:0]     rsp_info;
  logic              rsp_ready = 1'b1;

  always #5 clk = ~clk;

  tex_mem_latency_model #(
    .NUM_REQS(NR), .REQ_INFOW(IW), .LATENCY(LAT), .QUEUE_DEPTH(QD), .DATA_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tmask(req_tmask),
    .req_filter(req_filter), .req_lgstride(req_lgstride), .req_baseaddr(req_baseaddr),
    .req_addr(req_addr), .req_info(req_info), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
    .rsp_info(rsp_info), .rsp_ready(rsp_ready)
  );

  typedef struct {
    logic [NR-1:0]     tmask;
    logic [NR*128-1:0] data;
    logic [IW-1:0]     info;
    int                rdy;
  } exp_t;

  exp_t          q[$];
  logic [IW-1:0] got_info[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            dut_acc = 0;
  int            t_cyc = 0;
  bit            ready_en = 1'b0;
  bit            t_acc = 1'b0;
  bit            snap_valid = 1'b0;
  logic [511:0]  snap_data = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  // Texel value straight from the memory-image rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_texel(input logic [31:0] base, input logic [31:0] idx,
                                            input int lg);
    int unsigned sz;
    logic [31:0] a, w, m;
    sz = (lg >= 2) ? 4 : (1 << lg);
    a  = base + idx * sz;
    w  = a / 4;
    m  = (((w % 65536) * 65536) | (65535 - (w % 65536))) ^ SEED;
    if (sz == 1) return (m >> (8 * (a % 4))) % 256;
    if (sz == 2) return (m >> (16 * ((a / 2) % 2))) % 65536;
    return m;
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    e.tmask = req_tmask;
    e.info  = req_info;
    e.data  = '0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 4; j++)
        if (req_tmask[i] && (j == 0 || req_filter == 1'b1))
          e.data[(i*4+j)*32 +: 32] = ref_texel(req_baseaddr[i*32 +: 32],
                                               req_addr[(i*4+j)*32 +: 32], int'(req_lgstride));
    e.rdy = cyc + 1 + LAT;
    return e;
  endfunction

  task automatic rand_fields();
    req_tmask    = NR'($urandom);
    req_filter   = 1'($urandom);
    req_lgstride = 2'($urandom);
    for (int i = 0; i < NR; i++) req_baseaddr[i*32 +: 32] = $urandom;
    for (int k = 0; k < NR*4; k++) req_addr[k*32 +: 32] = $urandom_range(0, 4095);
  endtask

  // Check everything at the falling edge, advance the model, then step one clock.
  task automatic tick();
    bit   ev, er;
    exp_t e;
    @(negedge clk);
    t_cyc = cyc;
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    er = ready_en && ((q.size() < QD) || (ev && rsp_ready));
    chk("rsp_valid", rsp_valid, ev);
    chk("req_ready", req_ready, er);
    if (ev) begin
      chk("rsp_tmask", rsp_tmask, q[0].tmask);
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_info", rsp_info, q[0].info);
    end
    snap_valid = rsp_valid;
    snap_data  = rsp_data;
    t_acc      = req_valid && req_ready;
    if (t_acc) dut_acc++;
    if (rsp_valid && rsp_ready) got_info.push_back(rsp_info);
    if (ev && rsp_ready) void'(q.pop_front());
    if (req_valid && er) begin
      e = build_exp();
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    if (!reset) ready_en = 1'b1;
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    if (q.size() > 0) timeout(tag);
  endtask

  initial begin
    int acc_cyc, n, base_acc;

    // Reset and idle
    tick();
    tick();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 512'h0);
    chk("reset_rsp_tmask", rsp_tmask, 4'h0);
    chk("reset_rsp_info", rsp_info, 8'h0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Point sample, 32-bit stride, exact latency
    rand_fields();
    req_tmask    = 4'b0001;
    req_filter   = 1'b0;
    req_lgstride = 2'd2;
    req_baseaddr[31:0] = 32'h0000_1000;
    req_addr[31:0]     = 32'd1;
    req_info  = 8'hA5;
    req_valid = 1'b1;
    tick();
    acc_cyc = t_cyc;
    chk("point_accept", t_acc, 1'b1);
    req_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!snap_valid && n < 20);
    if (!snap_valid) timeout("point_wait");
    chk("point_latency", t_cyc - (acc_cyc + 1), LAT);
    chk("point_data", snap_data, {480'h0, 32'h0401_FBFE ^ SEED});
    drain("point_drain");

    // Bilinear, 8-bit stride, bytes of word 0
    rand_fields();
    req_tmask    = 4'b0001;
    req_filter   = 1'b1;
    req_lgstride = 2'd0;
    req_baseaddr[31:0] = 32'h0;
    for (int j = 0; j < 4; j++) req_addr[j*32 +: 32] = j;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!snap_valid && n < 20);
    if (!snap_valid) timeout("bilin_wait");
    chk("bilin_data", snap_data, {384'h0, 32'hC0, 32'hDE, 32'hFF, 32'hFF});
    drain("bilin_drain");

    // Back-pressure: credits fill at QUEUE_DEPTH, then bypass accept at full
    got_info.delete();
    base_acc  = dut_acc;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req_info = IW'(dut_acc - base_acc);
      tick();
      if (t_acc) rand_fields();
    end
    chk("full_accepts", dut_acc - base_acc, QD);
    chk("full_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1;
    req_info  = 8'd8;
    tick();
    chk("full_pop_accept", t_acc, 1'b1);
    rsp_ready = 1'b0;
    rand_fields();
    req_info = 8'd9;
    tick();
    chk("full_still_full", t_acc, 1'b0);
    rsp_ready = 1'b1;
    n = 0;
    while (dut_acc - base_acc < 10 && n < 20) begin
      tick();
      n++;
    end
    if (dut_acc - base_acc < 10) timeout("stream_accept");
    drain("stream_drain");
    chk("tag_count", got_info.size(), 10);
    for (int k = 0; k < 10 && k < got_info.size(); k++) chk("tag_order", got_info[k], k);

    // Reset with five requests in flight
    base_acc  = dut_acc;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    n = 0;
    while (dut_acc - base_acc < 5 && n < 20) begin
      rand_fields();
      req_info = $urandom;
      tick();
      n++;
    end
    req_valid = 1'b0;
    tick();
    tick();
    reset    = 1'b1;
    ready_en = 1'b0;
    q.delete();
    #1;
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_req_ready", req_ready, 1'b0);
    chk("midreset_rsp_data", rsp_data, 512'h0);
    tick();
    tick();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Random traffic against the model
    for (int k = 0; k < 500; k++) begin
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 4) != 0;
      rand_fields();
      req_info = $urandom;
      tick();
    end
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
